// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential 8-bit restoring divider, one quotient bit per clock
// Optional two's-complement mode: define DIV_SIGNED_EN.
module div_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nx;
  logic [8:0] p;
  logic [7:0] d;
  logic [7:0] yr;
  logic [2:0] cnt;
  logic       fin;
  logic       dbz_c;
  logic       accept;
  logic [8:0] p_sh;
  logic [8:0] t;
  logic [7:0] x_op;
  logic [7:0] y_op;
  logic [7:0] q_fix;
  logic [7:0] r_fix;

  assign accept = start && (state != CALC);
  assign p_sh   = {p[7:0], d[7]};
  assign t      = p_sh - {1'b0, yr};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign x_op  = x[7] ? (~x + 8'd1) : x;
  assign y_op  = y[7] ? (~y + 8'd1) : y;
  assign q_fix = neg_q ? (~d + 8'd1) : d;
  assign r_fix = neg_r ? (~p[7:0] + 8'd1) : p[7:0];

  // A zero divisor keeps the raw all-ones quotient; only the remainder is re-signed.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= (x[7] ^ y[7]) && (y != 8'd0);
      neg_r <= x[7];
    end
  end
`else
  assign x_op  = x;
  assign y_op  = y;
  assign q_fix = d;
  assign r_fix = p[7:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (fin)   state_nx = DONE;
      DONE:    state_nx = start ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // fin marks that all 8 iterations are in; the following CALC cycle retires the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      p     <= 9'd0;
      d     <= 8'd0;
      yr    <= 8'd0;
      cnt   <= 3'd0;
      fin   <= 1'b0;
      dbz_c <= 1'b0;
    end else if (accept) begin
      p     <= 9'd0;
      d     <= x_op;
      yr    <= y_op;
      cnt   <= 3'd0;
      fin   <= 1'b0;
      dbz_c <= (y == 8'd0);
    end else if (state == CALC && !fin) begin
      if (!t[8]) begin
        p <= t;
        d <= {d[6:0], 1'b1};
      end else begin
        p <= p_sh;
        d <= {d[6:0], 1'b0};
      end
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) fin <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q           <= 8'd0;
      r           <= 8'd0;
      div_by_zero <= 1'b0;
    end else if (state == CALC && fin) begin
      q           <= q_fix;
      r           <= r_fix;
      div_by_zero <= dbz_c;
    end
  end

endmodule
